// File: rtl/gates_seq.sv
// Bitwise gate sequencer: emits one result beat (single mode) or a six-op sweep over latched operands.
// Optional build macro GATES_SEQ_PARITY_EN adds a registered out_parity output (XOR-reduction of z).
module gates_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [2:0]       out_op,
  output logic             out_last,
  output logic             out_err
`ifdef GATES_SEQ_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned OPW     = 3;
  localparam logic [OPW-1:0] OP_AND  = OPW'(0);
  localparam logic [OPW-1:0] OP_NAND = OPW'(1);
  localparam logic [OPW-1:0] OP_OR   = OPW'(2);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_XNOR = OPW'(5);
  localparam logic [OPW-1:0] OP_LAST = OP_XNOR;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Bitwise op on two operands; illegal codes yield zero.
  function automatic logic [WIDTH-1:0] gate_eval(input logic [OPW-1:0] sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      OP_AND:  r = x & y;
      OP_NAND: r = ~(x & y);
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_d;
  logic [WIDTH-1:0] z_d;
  logic [OPW-1:0]   op_d;
  logic             last_d;
  logic             err_d;
  logic             accept;
  logic             consume;
  logic [OPW-1:0]   op_inc;

  // State and beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      z         <= '0;
      out_op    <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_valid <= valid_d;
      z         <= z_d;
      out_op    <= op_d;
      out_last  <= last_d;
      out_err   <= err_d;
    end
  end

  // Next-state and next-beat logic; a new acceptance always wins over going idle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    valid_d  = out_valid;
    z_d      = z;
    op_d     = out_op;
    last_d   = out_last;
    err_d    = out_err;
    consume  = out_valid & out_ready;
    in_ready = (state_q == IDLE) | (consume & out_last);
    accept   = in_valid & in_ready;
    op_inc   = out_op + OPW'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (consume) begin
          if (!out_last) begin
            op_d   = op_inc;
            z_d    = gate_eval(op_inc, a_q, b_q);
            last_d = (op_inc == OP_LAST);
            err_d  = 1'b0;
          end else if (!accept) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (accept) begin
      state_d = EMIT;
      valid_d = 1'b1;
      a_d     = a;
      b_d     = b;
      if (mode) begin
        op_d   = OP_AND;
        z_d    = gate_eval(OP_AND, a, b);
        last_d = 1'b0;
        err_d  = 1'b0;
      end else begin
        op_d   = op;
        z_d    = gate_eval(op, a, b);
        last_d = 1'b1;
        err_d  = (op > OP_LAST);
      end
    end
  end

`ifdef GATES_SEQ_PARITY_EN
  // Parity tracks z exactly, so it is computed from the next-z value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else begin
      out_parity <= ^z_d;
    end
  end
`endif

endmodule

// File: tb/tb_gates_seq.sv
// Directed self-checking bench for gates_seq (WIDTH=8), one task per scenario.
`timescale 1ns/1ps
module tb_gates_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic [2:0] out_op;
  logic       out_last;
  logic       out_err;
`ifdef GATES_SEQ_PARITY_EN
  logic       out_parity;
`endif

  int checks;
  int passed;

  gates_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .out_op    (out_op),
    .out_last  (out_last),
    .out_err   (out_err)
`ifdef GATES_SEQ_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    checks++;
    if ({out_valid, z, out_op, out_last, out_err} !== 14'd0)
      $display("FAIL reset_outputs: got v=%b z=%h op=%0d last=%b err=%b, want all 0",
               out_valid, z, out_op, out_last, out_err);
    else passed++;
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  // Single-mode beat for each legal op over two operand pairs.
  task automatic test_single();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [7:0] exp_z [2][6];
    av[0] = 8'hF0; bv[0] = 8'hCC;
    av[1] = 8'hA5; bv[1] = 8'h0F;
    exp_z[0][0] = 8'hC0; exp_z[0][1] = 8'h3F; exp_z[0][2] = 8'hFC;
    exp_z[0][3] = 8'h03; exp_z[0][4] = 8'h3C; exp_z[0][5] = 8'hC3;
    exp_z[1][0] = 8'h05; exp_z[1][1] = 8'hFA; exp_z[1][2] = 8'hAF;
    exp_z[1][3] = 8'h50; exp_z[1][4] = 8'hAA; exp_z[1][5] = 8'h55;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 6; k++) begin
        in_valid = 1'b1; a = av[p]; b = bv[p]; op = 3'(k); mode = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0; a = '0; b = '0;
        checks++;
        if (out_valid !== 1'b1 || z !== exp_z[p][k] || out_op !== 3'(k) ||
            out_last !== 1'b1 || out_err !== 1'b0)
          $display("FAIL single_p%0d_op%0d: got v=%b z=%h op=%0d last=%b err=%b, want v=1 z=%h op=%0d last=1 err=0",
                   p, k, out_valid, z, out_op, out_last, out_err, exp_z[p][k], k);
        else passed++;
`ifdef GATES_SEQ_PARITY_EN
        checks++;
        if (out_parity !== ^exp_z[p][k])
          $display("FAIL parity_p%0d_op%0d: got %b want %b", p, k, out_parity, ^exp_z[p][k]);
        else passed++;
`endif
        step();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL single_idle_p%0d_op%0d: got v=%b want 0", p, k, out_valid);
        else passed++;
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_z [6];
    exp_z[0] = 8'hC0; exp_z[1] = 8'h3F; exp_z[2] = 8'hFC;
    exp_z[3] = 8'h03; exp_z[4] = 8'h3C; exp_z[5] = 8'hC3;
    in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'd6; mode = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1 || z !== exp_z[k] || out_op !== 3'(k) ||
          out_last !== (k == 5) || out_err !== 1'b0)
        $display("FAIL sweep_beat%0d: got v=%b z=%h op=%0d last=%b err=%b, want v=1 z=%h op=%0d last=%b err=0",
                 k, out_valid, z, out_op, out_last, out_err, exp_z[k], k, (k == 5));
      else passed++;
      step();
    end
    checks++;
    if (out_valid !== 1'b0) $display("FAIL sweep_end: got v=%b want 0", out_valid);
    else passed++;
  endtask

  // Backpressure on beat 1, with ignored requests arriving while in_ready is low.
  task automatic test_stall();
    logic [7:0] exp_z [6];
    exp_z[0] = 8'hC0; exp_z[1] = 8'h3F; exp_z[2] = 8'hFC;
    exp_z[3] = 8'h03; exp_z[4] = 8'h3C; exp_z[5] = 8'hC3;
    in_valid = 1'b1; a = 8'hF0; b = 8'hCC; mode = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; a = 8'h00; b = 8'hFF; mode = 1'b0; op = 3'd2;
    checks++;
    if (z !== 8'hC0 || out_op !== 3'd0) $display("FAIL stall_beat0: got z=%h op=%0d want C0/0", z, out_op);
    else passed++;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || z !== 8'h3F || out_op !== 3'd1 || out_last !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%b z=%h op=%0d last=%b rdy=%b, want v=1 z=3F op=1 last=0 rdy=0",
                 c, out_valid, z, out_op, out_last, in_ready);
      else passed++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1 || z !== exp_z[k] || out_op !== 3'(k) || out_last !== (k == 5))
        $display("FAIL stall_resume%0d: got v=%b z=%h op=%0d last=%b, want v=1 z=%h op=%0d last=%b",
                 k, out_valid, z, out_op, out_last, exp_z[k], k, (k == 5));
      else passed++;
      step();
    end
    checks++;
    if (out_valid !== 1'b0) $display("FAIL stall_end: got v=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'd7; mode = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || z !== 8'h00 || out_op !== 3'd7 || out_last !== 1'b1 || out_err !== 1'b1)
      $display("FAIL illegal_op7: got v=%b z=%h op=%0d last=%b err=%b, want v=1 z=00 op=7 last=1 err=1",
               out_valid, z, out_op, out_last, out_err);
    else passed++;
    step();
    in_valid = 1'b1; op = 3'd0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || z !== 8'hC0 || out_err !== 1'b0)
      $display("FAIL illegal_clear: got v=%b z=%h err=%b, want v=1 z=C0 err=0", out_valid, z, out_err);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'd4; mode = 1'b0; out_ready = 1'b1;
    step();
    op = 3'd2; a = 8'hAA; b = 8'h55;
    checks++;
    if (out_valid !== 1'b1 || z !== 8'h3C || in_ready !== 1'b1)
      $display("FAIL b2b_first: got v=%b z=%h rdy=%b, want v=1 z=3C rdy=1", out_valid, z, in_ready);
    else passed++;
    step();
    op = 3'd0; a = 8'hF0; b = 8'hCC; mode = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || z !== 8'hFF || out_op !== 3'd2 || out_last !== 1'b1)
      $display("FAIL b2b_second: got v=%b z=%h op=%0d last=%b, want v=1 z=FF op=2 last=1",
               out_valid, z, out_op, out_last);
    else passed++;
    step();
    in_valid = 1'b0; mode = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || z !== 8'hC0 || out_op !== 3'd0 || out_last !== 1'b0)
      $display("FAIL b2b_sweep: got v=%b z=%h op=%0d last=%b, want v=1 z=C0 op=0 last=0",
               out_valid, z, out_op, out_last);
    else passed++;
    repeat (6) step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_end: got v=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; a = 8'hF0; b = 8'hCC; mode = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; mode = 1'b0;
    step();
    step();
    checks++;
    if (z !== 8'hFC || out_op !== 3'd2) $display("FAIL rstmid_beat2: got z=%h op=%0d want FC/2", z, out_op);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, z, out_op, out_last, out_err} !== 14'd0)
      $display("FAIL rstmid_async: got v=%b z=%h op=%0d last=%b err=%b, want all 0",
               out_valid, z, out_op, out_last, out_err);
    else passed++;
`ifdef GATES_SEQ_PARITY_EN
    checks++;
    if (out_parity !== 1'b0) $display("FAIL rstmid_parity: got %b want 0", out_parity);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready);
    else passed++;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_nobeat%0d: got v=%b want 0", c, out_valid);
      else passed++;
      step();
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
